// File: rtl/spm_flash_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spm_flash_ctrl : SPM page buffer, page erase/write engine, lock bits, RWWSB
// Rev 1.0
// ---------------------------------------------------------------------------
module spm_flash_ctrl #(
  parameter int         PM_AW     = 15,
  parameter int         PG_AW     = 5,
  parameter int         WORD_DLY  = 0,
  parameter logic [7:0] LOCK_INIT = 8'hFF
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic [15:0]      z_adr,
  input  logic [15:0]      spm_out,
  input  logic             rwwsre_op,
  input  logic             blbset_op,
  input  logic             pgwrt_op,
  input  logic             pgers_op,
  input  logic             spmen_op,
  output logic             rwwsre_rdy,
  output logic             blbset_rdy,
  output logic             pgwrt_rdy,
  output logic             pgers_rdy,
  output logic             spmen_rdy,
  output logic [PM_AW-1:0] pm_adr,
  output logic [15:0]      pm_dout,
  output logic             pm_we,
  output logic [7:0]       lock_bits,
  output logic             rwwsb,
  output logic             busy
);

  localparam int               C_PWORDS = 1 << PG_AW;
  localparam int               C_PBW    = PM_AW - PG_AW;
  localparam logic [PG_AW-1:0] C_LAST   = {PG_AW{1'b1}};
  localparam logic [7:0]       C_DLY    = WORD_DLY[7:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BUFWR = 3'd1,
    S_ERASE = 3'd2,
    S_PGWR  = 3'd3,
    S_BLB   = 3'd4,
    S_RWW   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            r_state;
  logic [C_PBW-1:0]  r_page;
  logic [PG_AW-1:0]  r_idx;
  logic [15:0]       r_data;
  logic [PG_AW-1:0]  r_cnt;
  logic [7:0]        r_dly;
  logic [15:0]       r_buf [0:C_PWORDS-1];

  logic              w_any_op;
  logic [PG_AW-1:0]  w_cnt_nxt;
  logic [C_PBW-1:0]  w_z_page;
  logic              w_unused;

  assign w_any_op  = rwwsre_op | blbset_op | pgwrt_op | pgers_op | spmen_op;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_z_page  = z_adr[PM_AW:PG_AW+1];
  assign w_unused  = z_adr[0];
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_state    <= S_IDLE;
      r_page     <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_dly      <= '0;
      rwwsre_rdy <= 1'b0;
      blbset_rdy <= 1'b0;
      pgwrt_rdy  <= 1'b0;
      pgers_rdy  <= 1'b0;
      spmen_rdy  <= 1'b0;
      pm_adr     <= '0;
      pm_dout    <= '0;
      pm_we      <= 1'b0;
      lock_bits  <= LOCK_INIT;
      rwwsb      <= 1'b0;
      for (int i = 0; i < C_PWORDS; i++) r_buf[i] <= 16'hFFFF;
    end else begin
      rwwsre_rdy <= 1'b0;
      blbset_rdy <= 1'b0;
      pgwrt_rdy  <= 1'b0;
      pgers_rdy  <= 1'b0;
      spmen_rdy  <= 1'b0;
      pm_we      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_page <= w_z_page;
          r_idx  <= z_adr[PG_AW:1];
          r_data <= spm_out;
          r_cnt  <= '0;
          r_dly  <= '0;
          // Word 0 is launched straight from the accept edge so the strobe
          // lands in the first ERASE/PGWR cycle.
          if (pgers_op) begin
            r_state <= S_ERASE;
            rwwsb   <= 1'b1;
            pm_we   <= 1'b1;
            pm_adr  <= {w_z_page, {PG_AW{1'b0}}};
            pm_dout <= 16'hFFFF;
          end else if (pgwrt_op) begin
            r_state <= S_PGWR;
            rwwsb   <= 1'b1;
            pm_we   <= 1'b1;
            pm_adr  <= {w_z_page, {PG_AW{1'b0}}};
            pm_dout <= r_buf[0];
          end else if (blbset_op) begin
            r_state    <= S_BLB;
            blbset_rdy <= 1'b1;
          end else if (rwwsre_op) begin
            r_state    <= S_RWW;
            rwwsre_rdy <= 1'b1;
          end else if (spmen_op) begin
            r_state   <= S_BUFWR;
            spmen_rdy <= 1'b1;
          end
        end

        S_BUFWR: begin
          r_buf[r_idx] <= r_data;
          r_state      <= S_DONE;
        end

        S_BLB: begin
          lock_bits <= lock_bits & r_data[7:0];
          r_state   <= S_DONE;
        end

        S_RWW: begin
          rwwsb   <= 1'b0;
          r_state <= S_DONE;
        end

        S_ERASE, S_PGWR: begin
          if (r_dly != C_DLY) begin
            r_dly <= r_dly + 8'd1;
          end else if (r_cnt == C_LAST) begin
            r_state <= S_DONE;
            if (r_state == S_ERASE) begin
              pgers_rdy <= 1'b1;
            end else begin
              pgwrt_rdy <= 1'b1;
              for (int i = 0; i < C_PWORDS; i++) r_buf[i] <= 16'hFFFF;
            end
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_dly   <= '0;
            pm_we   <= 1'b1;
            pm_adr  <= {r_page, w_cnt_nxt};
            pm_dout <= (r_state == S_ERASE) ? 16'hFFFF : r_buf[w_cnt_nxt];
          end
        end

        // Upstream still holds the op during the rdy cycle; wait for release.
        S_DONE: begin
          if (!w_any_op) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spm_flash_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spm_flash_ctrl : directed vector bench for spm_flash_ctrl (WORD_DLY=2)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spm_flash_ctrl;

  localparam int DLY = 2;

  logic        cp2;
  logic        ireset;
  logic [15:0] z_adr;
  logic [15:0] spm_out;
  logic        rwwsre_op, blbset_op, pgwrt_op, pgers_op, spmen_op;
  logic        rwwsre_rdy, blbset_rdy, pgwrt_rdy, pgers_rdy, spmen_rdy;
  logic [14:0] pm_adr;
  logic [15:0] pm_dout;
  logic        pm_we;
  logic [7:0]  lock_bits;
  logic        rwwsb;
  logic        busy;

  spm_flash_ctrl #(
    .PM_AW    (15),
    .PG_AW    (5),
    .WORD_DLY (DLY),
    .LOCK_INIT(8'hFF)
  ) u_dut (
    .cp2       (cp2),
    .ireset    (ireset),
    .z_adr     (z_adr),
    .spm_out   (spm_out),
    .rwwsre_op (rwwsre_op),
    .blbset_op (blbset_op),
    .pgwrt_op  (pgwrt_op),
    .pgers_op  (pgers_op),
    .spmen_op  (spmen_op),
    .rwwsre_rdy(rwwsre_rdy),
    .blbset_rdy(blbset_rdy),
    .pgwrt_rdy (pgwrt_rdy),
    .pgers_rdy (pgers_rdy),
    .spmen_rdy (spmen_rdy),
    .pm_adr    (pm_adr),
    .pm_dout   (pm_dout),
    .pm_we     (pm_we),
    .lock_bits (lock_bits),
    .rwwsb     (rwwsb),
    .busy      (busy)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  // op/rdy vector order: {pgers, pgwrt, blbset, rwwsre, spmen}
  localparam logic [4:0] OP_SPM = 5'b00001;
  localparam logic [4:0] OP_RWW = 5'b00010;
  localparam logic [4:0] OP_BLB = 5'b00100;
  localparam logic [4:0] OP_PGW = 5'b01000;
  localparam logic [4:0] OP_ERS = 5'b10000;

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic [15:0] z;
    logic [15:0] d;
    int          lat;
    logic [7:0]  lock;
    logic        rww;
  } vec_t;

  typedef struct {
    longint      t;
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  wire logic [4:0] w_rdys = {pgers_rdy, pgwrt_rdy, blbset_rdy, rwwsre_rdy, spmen_rdy};

  int          errors = 0;
  int          checks = 0;
  int          viol   = 0;
  logic [4:0]  prev_rdys = '0;
  wr_t         wq[$];
  logic [15:0] mbuf [0:31];
  vec_t        tbl [7];

  always @(negedge cp2) begin
    if (pm_we) wq.push_back('{longint'($time), pm_adr, pm_dout});
    if ($countones(w_rdys) > 1) viol++;
    if ((w_rdys & prev_rdys) != 5'd0) viol++;
    if (pm_we && !busy) viol++;
    prev_rdys = w_rdys;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input logic [4:0] o);
    {pgers_op, pgwrt_op, blbset_op, rwwsre_op, spmen_op} = o;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 50) begin
      @(negedge cp2);
      n++;
    end
    chk({nm, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    int          nexp;
    logic [4:0]  got;
    longint      t0;
    logic [14:0] base;
    logic [15:0] ed;
    wq.delete();
    @(negedge cp2);
    set_ops(v.op);
    z_adr   = v.z;
    spm_out = v.d;
    t0      = longint'($time);
    lat     = 0;
    got     = '0;
    while (got == 5'd0 && lat < 400) begin
      @(negedge cp2);
      lat++;
      got = w_rdys;
    end
    chk({v.nm, " rdy"}, {27'd0, got}, {27'd0, v.op});
    chk({v.nm, " latency"}, lat, v.lat);
    @(negedge cp2);
    set_ops(5'd0);
    wait_idle(v.nm);
    chk({v.nm, " lock_bits"}, {24'd0, lock_bits}, {24'd0, v.lock});
    chk({v.nm, " rwwsb"}, {31'd0, rwwsb}, {31'd0, v.rww});
    nexp = (v.op[4] | v.op[3]) ? 32 : 0;
    chk({v.nm, " write count"}, wq.size(), nexp);
    base = {v.z[15:6], 5'd0};
    for (int k = 0; k < wq.size() && k < nexp; k++) begin
      ed = v.op[4] ? 16'hFFFF : mbuf[k];
      chk($sformatf("%s w%0d adr", v.nm, k), {17'd0, wq[k].a}, {17'd0, base} + k);
      chk($sformatf("%s w%0d data", v.nm, k), {16'd0, wq[k].d}, {16'd0, ed});
      chk($sformatf("%s w%0d cycle", v.nm, k), int'((wq[k].t - t0) / 10), 1 + (1 + DLY) * k);
    end
    if (v.op[0]) mbuf[v.z[5:1]] = v.d;
    if (v.op[3]) for (int i = 0; i < 32; i++) mbuf[i] = 16'hFFFF;
  endtask

  initial begin
    int n;
    int extra;
    vec_t hv;

    tbl[0] = '{nm:"spmen A55A",  op:OP_SPM, z:16'h0006, d:16'hA55A, lat:1,  lock:8'hFF, rww:1'b0};
    tbl[1] = '{nm:"pgwrt page0", op:OP_PGW, z:16'h0000, d:16'h0000, lat:97, lock:8'hFF, rww:1'b1};
    tbl[2] = '{nm:"rwwsre 1",    op:OP_RWW, z:16'h0000, d:16'h0000, lat:1,  lock:8'hFF, rww:1'b0};
    tbl[3] = '{nm:"blbset F3",   op:OP_BLB, z:16'h0000, d:16'h00F3, lat:1,  lock:8'hF3, rww:1'b0};
    tbl[4] = '{nm:"blbset CF",   op:OP_BLB, z:16'h0000, d:16'h00CF, lat:1,  lock:8'hC3, rww:1'b0};
    tbl[5] = '{nm:"pgers 0040",  op:OP_ERS, z:16'h0040, d:16'h1111, lat:97, lock:8'hC3, rww:1'b1};
    tbl[6] = '{nm:"rwwsre 2",    op:OP_RWW, z:16'h0000, d:16'h0000, lat:1,  lock:8'hC3, rww:1'b0};
    for (int i = 0; i < 32; i++) mbuf[i] = 16'hFFFF;

    ireset  = 1'b1;
    z_adr   = '0;
    spm_out = '0;
    set_ops(5'd0);
    repeat (3) @(negedge cp2);
    chk("reset rdys", {27'd0, w_rdys}, 32'd0);
    chk("reset pm_we", {31'd0, pm_we}, 32'd0);
    chk("reset pm_adr", {17'd0, pm_adr}, 32'd0);
    chk("reset pm_dout", {16'd0, pm_dout}, 32'd0);
    chk("reset lock_bits", {24'd0, lock_bits}, 32'hFF);
    chk("reset rwwsb", {31'd0, rwwsb}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    ireset = 1'b0;
    @(negedge cp2);
    chk("post-reset busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Fill the whole page buffer, then program page 5 (word 0xA0..0xBF).
    for (int i = 0; i < 32; i++) begin
      hv = '{nm:$sformatf("fill %0d", i), op:OP_SPM, z:16'(2 * i), d:16'(16'h1000 + i),
             lat:1, lock:8'hC3, rww:1'b0};
      run_vec(hv);
    end
    hv = '{nm:"pgwrt 0140", op:OP_PGW, z:16'h0140, d:16'h0000, lat:97, lock:8'hC3, rww:1'b1};
    run_vec(hv);
    hv.nm = "pgwrt cleared buf";
    run_vec(hv);
    hv = '{nm:"rwwsre 3", op:OP_RWW, z:16'h0000, d:16'h0000, lat:1, lock:8'hC3, rww:1'b0};
    run_vec(hv);

    // spmen held through DONE with changed data must not write a second time.
    @(negedge cp2);
    spmen_op = 1'b1;
    z_adr    = 16'h0008;
    spm_out  = 16'h1234;
    n = 0;
    while (!spmen_rdy && n < 20) begin
      @(negedge cp2);
      n++;
    end
    chk("hold first rdy latency", n, 1);
    spm_out = 16'h5678;
    extra = 0;
    repeat (8) begin
      @(negedge cp2);
      if (spmen_rdy) extra++;
    end
    chk("hold extra rdy", extra, 0);
    chk("hold busy in done", {31'd0, busy}, 32'd1);
    spmen_op = 1'b0;
    wait_idle("hold");
    mbuf[4] = 16'h1234;
    hv = '{nm:"pgwrt after hold", op:OP_PGW, z:16'h0000, d:16'h0000, lat:97, lock:8'hC3, rww:1'b1};
    run_vec(hv);

    // Reset in the middle of an erase.
    hv = '{nm:"spmen BEEF", op:OP_SPM, z:16'h000A, d:16'hBEEF, lat:1, lock:8'hC3, rww:1'b1};
    run_vec(hv);
    wq.delete();
    @(negedge cp2);
    pgers_op = 1'b1;
    z_adr    = 16'h0080;
    n = 0;
    while (wq.size() < 11 && n < 200) begin
      @(negedge cp2);
      #1;
      n++;
    end
    chk("abort reached word10", wq.size(), 11);
    if (wq.size() >= 11) chk("abort word10 adr", {17'd0, wq[10].a}, 32'h004A);
    ireset = 1'b1;
    #1;
    chk("abort pm_we", {31'd0, pm_we}, 32'd0);
    chk("abort rdys", {27'd0, w_rdys}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort rwwsb", {31'd0, rwwsb}, 32'd0);
    chk("abort lock_bits", {24'd0, lock_bits}, 32'hFF);
    chk("abort pm_adr", {17'd0, pm_adr}, 32'd0);
    pgers_op = 1'b0;
    repeat (3) @(negedge cp2);
    ireset = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge cp2);
      if (w_rdys != 5'd0 || pm_we) extra++;
    end
    chk("abort no late rdy", extra, 0);
    chk("abort idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 32; i++) mbuf[i] = 16'hFFFF;
    hv = '{nm:"pgwrt after reset", op:OP_PGW, z:16'h0080, d:16'h0000, lat:97, lock:8'hFF, rww:1'b1};
    run_vec(hv);

    chk("protocol violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
